// File: rtl/fpi2c_pkg.sv
// Shared types and constants for the front-panel I2C target.
package fpi2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDRACK,
        WRPTR,
        WRDATA,
        WRACK,
        RDDATA,
        RDACK,
        IGNORE
    } state_t;

    localparam logic [6:0] FP_DEVADDR = 7'h20;

endpackage

// File: rtl/i2c_busfilt.sv
// Synchronizes and debounces the SCL/SDA pair, then derives SCL edge and
// START/STOP pulses from the filtered levels.
module i2c_busfilt #(
    parameter int FILT = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic sclin,
    input  logic sdain,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    localparam int            CW   = $clog2(FILT + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILT - 1);

    // bit 0 carries SCL, bit 1 carries SDA
    logic [1:0]    raw_p0, raw_p1;
    logic [1:0]    lvl, lvl_d;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            raw_p0 <= 2'b11;
            raw_p1 <= 2'b11;
            lvl    <= 2'b11;
            lvl_d  <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            raw_p0 <= {sdain, sclin};
            raw_p1 <= raw_p0;
            lvl_d  <= lvl;
            // A new level is accepted only after FILT consecutive differing samples.
            for (int i = 0; i < 2; i++) begin
                if (raw_p1[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    lvl[i] <= raw_p1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sda      = lvl[1];
    assign scl_rise = lvl[0] & ~lvl_d[0];
    assign scl_fall = ~lvl[0] & lvl_d[0];
    assign start    = lvl[0] & lvl_d[0] & lvl_d[1] & ~lvl[1];
    assign stop     = lvl[0] & lvl_d[0] & ~lvl_d[1] & lvl[1];

endmodule

// File: rtl/i2c_fptarget.sv
// MCP23017-style byte-register I2C target for the front-panel bus, with a
// host-side port into the same register file.
module i2c_fptarget
    import fpi2c_pkg::*;
#(
    parameter logic [6:0] DEVADDR  = FP_DEVADDR,
    parameter int         NREGLOG2 = 5,
    parameter int         FILT     = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                sclin,
    input  logic                sdain,
    output logic                sdaout,
    input  logic                hostwrite,
    input  logic [NREGLOG2-1:0] hostwaddr,
    input  logic [7:0]          hostwdata,
    input  logic [NREGLOG2-1:0] hostraddr,
    output logic [7:0]          hostrdata,
    output logic                wrstrobe,
    output logic [NREGLOG2-1:0] wraddr,
    output logic [7:0]          wrdata,
    output logic                busy
);
    localparam int NREG = 1 << NREGLOG2;

    logic                sda, scl_rise, scl_fall, start, stop;
    state_t              state;
    logic [3:0]          bitcnt;
    logic                phase, rw;
    logic [7:0]          shreg;
    logic [NREGLOG2-1:0] ptr;
    logic [7:0]          regs [NREG];
    logic [7:0]          inbyte, rdbyte;
    logic                commit;

    i2c_busfilt #(.FILT(FILT)) u_busfilt (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .sclin    (sclin),
        .sdain    (sdain),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign inbyte    = {shreg[6:0], sda};
    assign rdbyte    = regs[ptr];
    assign hostrdata = regs[hostraddr];
    assign commit    = (state == WRDATA) && scl_rise && (bitcnt == 4'd7);

    // Host write is applied last so it wins a same-cycle collision.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (commit)    regs[ptr]       <= inbyte;
            if (hostwrite) regs[hostwaddr] <= hostwdata;
        end
    end

    always_ff @(posedge CLOCK) begin
        wrstrobe <= 1'b0;
        if (RESET) begin
            state  <= IDLE;
            sdaout <= 1'b1;
            busy   <= 1'b0;
            wraddr <= '0;
            wrdata <= '0;
            ptr    <= '0;
            bitcnt <= '0;
            phase  <= 1'b0;
            rw     <= 1'b0;
            shreg  <= '0;
        end else if (start) begin
            state  <= ADDR;
            bitcnt <= '0;
            phase  <= 1'b0;
            sdaout <= 1'b1;
            busy   <= 1'b1;
        end else if (stop) begin
            state  <= IDLE;
            phase  <= 1'b0;
            sdaout <= 1'b1;
            busy   <= 1'b0;
        end else begin
            case (state)
                ADDR, WRPTR, WRDATA: begin
                    if (scl_rise) begin
                        shreg  <= inbyte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            bitcnt <= '0;
                            if (state == ADDR) begin
                                if (inbyte[7:1] == DEVADDR) begin
                                    rw    <= inbyte[0];
                                    state <= ADDRACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == WRPTR) begin
                                ptr   <= inbyte[NREGLOG2-1:0];
                                state <= WRACK;
                            end else begin
                                wrstrobe <= 1'b1;
                                wraddr   <= ptr;
                                wrdata   <= inbyte;
                                ptr      <= ptr + 1'b1;
                                state    <= WRACK;
                            end
                        end
                    end
                end
                ADDRACK, WRACK: begin
                    // First fall pulls SDA low, second fall ends the ACK.
                    if (scl_fall) begin
                        phase  <= ~phase;
                        bitcnt <= '0;
                        if (!phase) begin
                            sdaout <= 1'b0;
                        end else if (state == ADDRACK && rw) begin
                            shreg  <= {rdbyte[6:0], 1'b0};
                            sdaout <= rdbyte[7];
                            bitcnt <= 4'd1;
                            state  <= RDDATA;
                        end else begin
                            sdaout <= 1'b1;
                            state  <= (state == ADDRACK) ? WRPTR : WRDATA;
                        end
                    end
                end
                RDDATA: begin
                    if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            sdaout <= 1'b1;
                            ptr    <= ptr + 1'b1;
                            phase  <= 1'b0;
                            state  <= RDACK;
                        end else begin
                            sdaout <= shreg[7];
                            shreg  <= {shreg[6:0], 1'b0};
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end
                end
                RDACK: begin
                    if (scl_rise) begin
                        if (sda) state <= IGNORE;
                        else     phase <= 1'b1;
                    end else if (scl_fall && phase) begin
                        shreg  <= {rdbyte[6:0], 1'b0};
                        sdaout <= rdbyte[7];
                        bitcnt <= 4'd1;
                        phase  <= 1'b0;
                        state  <= RDDATA;
                    end
                end
                default: sdaout <= 1'b1;
            endcase
        end
    end

endmodule

// File: doc/i2c_fptarget.md
Name: i2c_fptarget

Overview:
- I2C target (responder) at the far end of the front-panel I2C bus; it answers transactions issued by the front-panel I2C master.
- Models an MCP23017-style byte-register device: a write sets a register pointer and stores data bytes; a read returns bytes from that pointer.
- Used in simulation benches and as an on-fabric stand-in panel when no physical panel is fitted.
- Host/ARM side gets direct access to the register file, plus a strobe for every byte the master writes.

Parameters:
- DEVADDR, 7'h20, 7-bit I2C device address the block responds to.
- NREGLOG2, 5, log2 of register-file depth (default 32 bytes).
- FILT, 4, CLOCK cycles a synchronized SCL/SDA level must stay stable before it is accepted.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- sclin  in  1  bus SCL level, asynchronous.
- sdain  in  1  bus SDA level, asynchronous.
- sdaout  out  1  SDA drive: 0 pulls low, 1 releases (open-drain; wire-ANDed externally).
- hostwrite  in  1  host register write strobe.
- hostwaddr  in  NREGLOG2  host write address.
- hostwdata  in  8  host write data.
- hostraddr  in  NREGLOG2  host read address.
- hostrdata  out  8  combinational regs[hostraddr].
- wrstrobe  out  1  one-cycle pulse when a data byte from the master is committed.
- wraddr  out  NREGLOG2  register written at the last wrstrobe.
- wrdata  out  8  byte written at the last wrstrobe.
- busy  out  1  high from accepted START to STOP.

Behaviour:
- Input conditioning:
  - 2-flop synchronizer on each of sclin and sdain, followed by the FILT stability filter.
  - Filtered levels scl and sda reset to 1.
  - Edges are defined on the filtered levels only.
- Bus conditions:
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - Both are recognised in any state and override the state machine.
  - START (including repeated START) -> ADDR, bit counter cleared, sdaout released.
  - STOP -> IDLE, sdaout released.
- Bit timing:
  - Bits are sampled on scl rise.
  - sdaout changes only on scl fall, never while scl=1.
- States:
  - IDLE: sdaout=1; wait for START.
  - ADDR: shift 8 bits MSB first.
    - On the 8th rise: if [7:1]==DEVADDR, go to ADDRACK and latch rw=[0].
    - Otherwise go to IGNORE.
  - ADDRACK: sdaout=0 from the next fall to the fall after that.
    - rw=0 -> WRPTR.
    - rw=1 -> RDDATA; load shift register with regs[ptr] at the ack-ending fall.
  - WRPTR: 8 bits; on the 8th rise, ptr <= byte[NREGLOG2-1:0] (upper bits ignored) -> WRACK.
  - WRDATA: 8 bits; on the 8th rise:
    - regs[ptr] <= byte; pulse wrstrobe; wraddr=ptr, wrdata=byte.
    - ptr <= ptr+1 modulo 2^NREGLOG2 (wraps 31->0).
    - -> WRACK.
  - WRACK: drive ACK as in ADDRACK, then -> WRDATA.
  - RDDATA: drive shift-register bits on successive falls; the 8th bit is held until the following fall, which releases SDA -> RDACK.
    - ptr <= ptr+1 (wrapping) once the byte has been sent.
  - RDACK: sample master ack on rise.
    - 0 -> RDDATA; reload regs[ptr] at the next fall.
    - 1 (NACK) -> IGNORE.
  - IGNORE: sdaout=1; wait for START or STOP.
- Pointer persistence: ptr survives STOP and repeated START, so a pointer-only write followed by a read fetches from the set pointer.
- Register file:
  - Host write and I2C commit to the same register in the same cycle: host wins; wrstrobe still pulses.
  - Host write to the register currently loaded in the read shift register does not alter the byte in flight.
- Reset values: sdaout=1, busy=0, wrstrobe=0, wraddr=0, wrdata=0, ptr=0, state=IDLE; regs cleared to 0.
- Reset mid-transfer: sdaout is released within the same cycle RESET is sampled; the bus then stays ignored until the next START.
- No clock stretching. Minimum supported SCL half-period: FILT+4 CLOCK cycles.

Decomposition:
- Shared package fpi2c_pkg holds:
  - state enum: IDLE, ADDR, ADDRACK, WRPTR, WRDATA, WRACK, RDDATA, RDACK, IGNORE;
  - default FP device address constant 7'h20.
- One natural sub-module: i2c_busfilt (synchronizer + FILT filter + START/STOP/rise/fall pulse generation), instantiated once for the SCL/SDA pair.

Test Plan:
- Write 0x20+W, ptr 0x05, data 0xA5, 0x3C, STOP -> ACK on all 3 bytes; regs[5]=0xA5, regs[6]=0x3C; two wrstrobe pulses with wraddr 5 then 6; ptr=7.
- Host writes regs[0x1F]=0x11, regs[0]=0x22; master writes ptr 0x1F, repeated START, 0x20+R, reads 2 bytes (ACK then NACK), STOP -> returns 0x11 then 0x22 (wrap); busy falls at STOP.
- Address 0x21+W -> no ACK (SDA high on 9th clock); state IGNORE; no wrstrobe; regs unchanged.
- SDA glitch shorter than FILT cycles during scl=1 -> no START/STOP detected; transfer continues normally.
- RESET asserted while the target holds ACK low -> sdaout=1 the next cycle; following full write transaction behaves normally.
- Host write and I2C commit to regs[3] in the same cycle (host 0x77, I2C 0x55) -> regs[3]=0x77; wrstrobe asserted with wrdata=0x55.
